event_mod_counter: RTL and testbench
====================================

# event_mod_counter

Parametrised multi-channel modulo-N event counter, the successor to the fixed modulo-4 pulse detector. Each of `NUM_CH` independent channels counts single-cycle `data` events. Each channel raises a registered one-cycle `flag` when the event completing its period arrives. Period, wrap/one-shot mode and clearing are runtime-controlled and shared by all channels. The block sits between input event qualifiers and the interrupt/status logic.

## Interface
- `NUM_CH`, default 4: number of independent channels (≥1).
- `CNT_W`, default 2: counter width; the maximum period is 2^`CNT_W`.
- `DEF_MOD`, default 3: reset value of the terminal count. The default gives period 4, the legacy behaviour.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data`  in  `NUM_CH`  per-channel event strobe; 1 = one event this cycle.
- `clr`  in  1  synchronous clear of all channels.
- `cfg_ld`  in  1  load `mod_val` into the shared terminal-count register.
- `mod_val`  in  `CNT_W`  terminal count; period = `mod_val`+1.
- `mode`  in  1  0 = wrap, 1 = one-shot.
- `cnt`  out  `NUM_CH`*`CNT_W`  per-channel count; channel i occupies bits [i*`CNT_W` +: `CNT_W`].
- `flag`  out  `NUM_CH`  one-cycle terminal pulse, registered.
- `done`  out  `NUM_CH`  one-shot complete (level).

## Operation
- Shared register `mod_q` resets to `DEF_MOD`. When `cfg_ld`=1, `mod_q` takes `mod_val` on the next edge. Loading does not touch the counters.
- Each channel has two states: RUN and HALT. Reset puts every channel in RUN with `cnt`=0, `flag`=0, `done`=0.
- RUN with `data[i]`=0: the channel holds its count.
- RUN with `data[i]`=1 and `cnt` < `mod_q`: `cnt` increments.
- RUN with `data[i]`=1 and `cnt` ≥ `mod_q` (terminal event):
  - `flag[i]`=1 next cycle.
  - With `mode`=0, `cnt` returns to 0 and the channel stays in RUN.
  - With `mode`=1, `cnt` holds at its current value and the channel goes to HALT with `done[i]`=1.
- The ≥ comparison covers `mod_q` being lowered below a live count: the next event is terminal.
- `mod_q`=0 makes every event terminal.
- HALT: `data` is ignored, `flag`=0 and `done` is held at 1.
  - `clr` returns the channel to RUN with `cnt`=0 and `done`=0.
  - `mode`=0 while in HALT also returns the channel to RUN with `cnt`=0 and `done`=0. No flag is generated.
- Priority, highest first: `clr` > terminal/increment evaluation.
  - `clr` together with `data` drops the event: `cnt`=0 and no flag.
  - `cfg_ld` together with `data` evaluates the event against the old `mod_q`.
- `mode` is sampled every cycle. It is not latched per channel.
- Channels never interact. All channels can flag in the same cycle.

## Timing
- Every output is a flop with reset value 0.
- Latency is one cycle. A `data` event sampled at edge k updates `cnt` and `flag` and is visible after edge k.
- With the defaults, the 4th event sampled at edge k gives `flag`=1 for the cycle between edges k and k+1. This matches the legacy modulo-4 detector cycle-for-cycle.
- `flag` never lasts two consecutive cycles unless terminal events occur on consecutive cycles. This can happen only with `mod_q`=0, or back-to-back wrap when `mod_q`=0.
- `rst` asserted mid-count clears everything immediately (asynchronously). The first event after deassertion counts as event 1.
- A `cfg_ld` takes effect on the event one cycle after the load.

## Structure
- Shared package `event_mod_counter_pkg`:
  - mode constants `MODE_WRAP`=1'b0 and `MODE_ONESHOT`=1'b1;
  - channel state encoding `ST_RUN`/`ST_HALT`.
- Sub-module `event_mod_counter_ch`: one channel's FSM, counter and flag/done registers.
  - It takes `mod_q`, `mode` and `clr` as inputs.
  - The top instantiates it with a generate loop and owns `mod_q`.

## Test plan
- Defaults, `mode`=0, `data[0]` high for 8 consecutive cycles: `cnt[0]` sequence is 1,2,3,0,1,2,3,0; `flag[0]` pulses after the 4th and 8th events; other channels stay 0.
- `cfg_ld` with `mod_val`=1, `mode`=1, 3 events on channel 2: `flag[2]` pulses once after event 2; `done[2]`=1 and `cnt[2]`=1 hold; the 3rd event is ignored; after `clr`, `done[2]`=0 and `cnt[2]`=0.
- `cnt[1]`=3, then `cfg_ld` with `mod_val`=1, then 1 event: the event is terminal, `flag[1]`=1 and `cnt[1]`=0.
- `clr` and `data[3]` in the same cycle with `cnt[3]`=2: `cnt[3]`=0 and no flag.
- `mod_val`=0 and `data` all-ones for 3 cycles: `flag` is all-ones for 3 cycles and `cnt` stays 0.
- `rst` pulsed low mid-count with `cnt[0]`=2: all outputs 0 immediately; the following 4 events produce exactly one flag.

Source files
------------

// File: rtl/event_mod_counter_pkg.sv
// Shared definitions for the multi-channel modulo-N event counter:
// operating-mode constants and the per-channel state encoding.
package event_mod_counter_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ch_state_e;

endpackage

// File: rtl/event_mod_counter_ch.sv
// One counter channel: RUN/HALT state, modulo count, registered terminal
// flag and one-shot done level.
module event_mod_counter_ch
  import event_mod_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] mod_q,
  output logic [CNT_W-1:0] cnt,
  output logic             flag,
  output logic             done
);

  ch_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             flag_r, flag_s;
  logic             done_r, done_s;

  // State, count, flag and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
      cnt_r   <= '0;
      flag_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      flag_r  <= flag_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; clear outranks any event evaluation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    flag_s  = 1'b0;
    done_s  = done_r;
    if (clr) begin
      state_s = ST_RUN;
      cnt_s   = '0;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (data) begin
            // >= so that lowering mod_q below a live count makes the next event terminal
            if (cnt_r >= mod_q) begin
              flag_s = 1'b1;
              if (mode == MODE_ONESHOT) begin
                state_s = ST_HALT;
                done_s  = 1'b1;
              end else begin
                cnt_s = '0;
              end
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_HALT: begin
          if (mode == MODE_WRAP) begin
            state_s = ST_RUN;
            cnt_s   = '0;
            done_s  = 1'b0;
          end else begin
            done_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_RUN;
          cnt_s   = '0;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  assign cnt  = cnt_r;
  assign flag = flag_r;
  assign done = done_r;

endmodule

// File: rtl/event_mod_counter.sv
// Multi-channel modulo-N event counter: owns the shared terminal-count
// register and instantiates one independent channel per event strobe.
module event_mod_counter
  import event_mod_counter_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned DEF_MOD = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       data,
  input  logic                    clr,
  input  logic                    cfg_ld,
  input  logic [CNT_W-1:0]        mod_val,
  input  logic                    mode,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH-1:0]       done
);

  logic [CNT_W-1:0] mod_q;

  // Shared terminal count; a load only affects events from the next cycle on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_q <= CNT_W'(DEF_MOD);
    end else if (cfg_ld) begin
      mod_q <= mod_val;
    end else begin
      mod_q <= mod_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_mod_counter_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .data  (data[i]),
      .clr   (clr),
      .mode  (mode),
      .mod_q (mod_q),
      .cnt   (cnt[i*CNT_W +: CNT_W]),
      .flag  (flag[i]),
      .done  (done[i])
    );
  end

endmodule

// File: tb/tb_event_mod_counter.sv
// Self-checking bench for event_mod_counter: directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_event_mod_counter;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int DEFM = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    data;
  logic              clr;
  logic              cfg_ld;
  logic [CW-1:0]     mod_val;
  logic              mode;
  logic [NCH*CW-1:0] cnt;
  logic [NCH-1:0]    flag;
  logic [NCH-1:0]    done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt  [NCH];
  bit m_halt [NCH];
  bit m_flag [NCH];
  bit m_done [NCH];
  int m_mod;

  event_mod_counter #(.NUM_CH(NCH), .CNT_W(CW), .DEF_MOD(DEFM)) dut (
    .clk(clk), .rst(rst), .data(data), .clr(clr), .cfg_ld(cfg_ld),
    .mod_val(mod_val), .mode(mode), .cnt(cnt), .flag(flag), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_halt[c] = 0; m_flag[c] = 0; m_done[c] = 0;
    end
    m_mod = DEFM;
  endfunction

  // One clock edge of the rules, using the inputs present at the edge.
  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      m_flag[c] = 0;
      if (clr) begin
        m_cnt[c] = 0; m_halt[c] = 0; m_done[c] = 0;
      end else if (m_halt[c]) begin
        if (mode == 1'b0) begin
          m_halt[c] = 0; m_cnt[c] = 0; m_done[c] = 0;
        end
      end else if (data[c]) begin
        if (m_cnt[c] >= m_mod) begin
          m_flag[c] = 1;
          if (mode == 1'b0) m_cnt[c] = 0;
          else begin
            m_halt[c] = 1; m_done[c] = 1;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
    if (cfg_ld) m_mod = int'(mod_val);
  endfunction

  task automatic check_all(input string tag);
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0] ef, ed;
    for (int c = 0; c < NCH; c++) begin
      ec[c*CW +: CW] = CW'(m_cnt[c]);
      ef[c] = m_flag[c];
      ed[c] = m_done[c];
    end
    chk({tag, "_cnt"}, 32'(cnt), 32'(ec));
    chk({tag, "_flag"}, 32'(flag), 32'(ef));
    chk({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  task automatic step(input string tag, input logic [NCH-1:0] d, input logic c,
                      input logic ld, input logic [CW-1:0] mv, input logic m);
    data = d; clr = c; cfg_ld = ld; mod_val = mv; mode = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int exp_seq[8];
    int nflags;
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    rst = 1'b0; data = '0; clr = 1'b0; cfg_ld = 1'b0; mod_val = '0; mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst = 1'b1;

    // Legacy modulo-4 wrap on channel 0
    for (int k = 0; k < 8; k++) begin
      step("wrap", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("wrap_seq", 32'(cnt[1:0]), 32'(exp_seq[k]));
      chk("wrap_flag0", 32'(flag[0]), 32'((k == 3) || (k == 7)));
    end
    chk("wrap_others", 32'(cnt[7:2]), 32'd0);

    // One-shot with period 2 on channel 2
    step("ld1", 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) step("oneshot", 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("oneshot_done2", 32'(done[2]), 32'd1);
    chk("oneshot_cnt2", 32'(cnt[5:4]), 32'd1);
    step("oneshot_clr", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("clr_done2", 32'(done[2]), 32'd0);
    chk("clr_cnt2", 32'(cnt[5:4]), 32'd0);

    // Lowering mod_q below a live count
    step("ld3", 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
    for (int k = 0; k < 3; k++) step("ch1_cnt", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("ch1_at3", 32'(cnt[3:2]), 32'd3);
    step("ld_low", 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    step("lowered", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("lowered_flag1", 32'(flag[1]), 32'd1);
    chk("lowered_cnt1", 32'(cnt[3:2]), 32'd0);

    // Clear together with an event
    step("ld3b", 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
    for (int k = 0; k < 2; k++) step("ch3_cnt", 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0);
    step("clr_evt", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("clr_evt_cnt3", 32'(cnt[7:6]), 32'd0);
    chk("clr_evt_flag3", 32'(flag[3]), 32'd0);

    // mod_q = 0: every event terminal on every channel
    step("ld0", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("mod0", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("mod0_flag", 32'(flag), 32'hF);
      chk("mod0_cnt", 32'(cnt), 32'd0);
    end

    // Asynchronous reset mid-count
    step("ld3c", 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
    for (int k = 0; k < 2; k++) step("pre_rst", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("pre_rst_cnt0", 32'(cnt[1:0]), 32'd2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1 rst = 1'b1;
    nflags = 0;
    for (int k = 0; k < 4; k++) begin
      step("post_rst", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      nflags += int'(flag[0]);
    end
    chk("post_rst_flags", 32'(nflags), 32'd1);

    // Random traffic
    mode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic m;
      m = ($urandom_range(0, 9) == 0) ? ~mode : mode;
      step("rand", NCH'($urandom), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 14) == 0), CW'($urandom), m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
